// File: rtl/turn_sequencer.sv
// rtl/turn_sequencer.sv - two-player number-baseball turn/round sequencer
// Runs turns, scorer handshake, history commit strobes, per-turn timeout and win/draw decision.
module turn_sequencer #(
   parameter int MAX_ROUNDS     = 4,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int TW             = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       enter,
   input  logic       guess_valid,
   input  logic       score_valid,
   input  logic [1:0] strike,
   output logic       on_game,
   output logic       cur_player,
   output logic       score_req,
   output logic       commit_p1,
   output logic       commit_p2,
   output logic       hist_clear,
   output logic       reject,
   output logic       timeout,
   output logic [3:0] round,
   output logic       game_over,
   output logic [1:0] winner
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_TURN,
      S_SCORE,
      S_COMMIT,
      S_ROUND_END,
      S_GAME_OVER
   } state_t;

   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
   localparam logic [4:0]    MAX_R      = 5'(MAX_ROUNDS);

   state_t        state_q;
   logic [TW-1:0] timer_q;
   logic          win_p1_q;
   logic          win_p2_q;
   logic          on_game_q;
   logic          cur_player_q;
   logic          score_req_q;
   logic          commit_p1_q;
   logic          commit_p2_q;
   logic          hist_clear_q;
   logic          reject_q;
   logic          timeout_q;
   logic [3:0]    round_q;
   logic          game_over_q;
   logic [1:0]    winner_q;

   logic [4:0]    round_nx;
   logic [3:0]    round_d;
   logic          last_round;

   always_comb begin
      round_nx   = {1'b0, round_q} + 5'd1;
      last_round = (round_nx == MAX_R);
      round_d    = (round_nx >= MAX_R) ? MAX_R[3:0] : round_nx[3:0];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         timer_q      <= '0;
         win_p1_q     <= 1'b0;
         win_p2_q     <= 1'b0;
         on_game_q    <= 1'b0;
         cur_player_q <= 1'b0;
         score_req_q  <= 1'b0;
         commit_p1_q  <= 1'b0;
         commit_p2_q  <= 1'b0;
         hist_clear_q <= 1'b0;
         reject_q     <= 1'b0;
         timeout_q    <= 1'b0;
         round_q      <= 4'd0;
         game_over_q  <= 1'b0;
         winner_q     <= 2'd0;
      end else begin
         score_req_q  <= 1'b0;
         commit_p1_q  <= 1'b0;
         commit_p2_q  <= 1'b0;
         hist_clear_q <= 1'b0;
         reject_q     <= 1'b0;
         timeout_q    <= 1'b0;

         case (state_q)
            S_IDLE, S_GAME_OVER: begin
               if (start) begin
                  state_q      <= S_TURN;
                  hist_clear_q <= 1'b1;
                  on_game_q    <= 1'b1;
                  cur_player_q <= 1'b0;
                  round_q      <= 4'd0;
                  winner_q     <= 2'd0;
                  game_over_q  <= 1'b0;
                  win_p1_q     <= 1'b0;
                  win_p2_q     <= 1'b0;
                  timer_q      <= '0;
               end
            end

            S_TURN: begin
               if (enter) begin
                  if (guess_valid) begin
                     score_req_q <= 1'b1;
                     state_q     <= S_SCORE;
                     timer_q     <= '0;
                  end else begin
                     reject_q <= 1'b1;
                     timer_q  <= timer_q + TIMER_ONE;
                  end
               // >= rather than == so a rejected guess on the expiry cycle still times out next cycle
               end else if (timer_q >= TIMER_LAST) begin
                  timeout_q <= 1'b1;
                  timer_q   <= '0;
                  if (cur_player_q) begin
                     state_q <= S_ROUND_END;
                  end else begin
                     cur_player_q <= 1'b1;
                  end
               end else begin
                  timer_q <= timer_q + TIMER_ONE;
               end
            end

            S_SCORE: begin
               if (score_valid) begin
                  if (cur_player_q) begin
                     win_p2_q <= (strike == 2'd3);
                  end else begin
                     win_p1_q <= (strike == 2'd3);
                  end
                  state_q <= S_COMMIT;
               end
            end

            S_COMMIT: begin
               if (cur_player_q) begin
                  commit_p2_q <= 1'b1;
                  state_q     <= S_ROUND_END;
               end else begin
                  commit_p1_q  <= 1'b1;
                  cur_player_q <= 1'b1;
                  state_q      <= S_TURN;
               end
            end

            S_ROUND_END: begin
               round_q <= round_d;
               if (win_p1_q || win_p2_q || last_round) begin
                  state_q     <= S_GAME_OVER;
                  game_over_q <= 1'b1;
                  on_game_q   <= 1'b0;
                  if (win_p1_q && win_p2_q) begin
                     winner_q <= 2'd3;
                  end else if (win_p1_q) begin
                     winner_q <= 2'd1;
                  end else if (win_p2_q) begin
                     winner_q <= 2'd2;
                  end else begin
                     winner_q <= 2'd0;
                  end
               end else begin
                  state_q      <= S_TURN;
                  cur_player_q <= 1'b0;
               end
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign on_game    = on_game_q;
   assign cur_player = cur_player_q;
   assign score_req  = score_req_q;
   assign commit_p1  = commit_p1_q;
   assign commit_p2  = commit_p2_q;
   assign hist_clear = hist_clear_q;
   assign reject     = reject_q;
   assign timeout    = timeout_q;
   assign round      = round_q;
   assign game_over  = game_over_q;
   assign winner     = winner_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// tb/tb_turn_sequencer.sv - directed self-checking bench for turn_sequencer
module tb_turn_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       enter = 1'b0;
   logic       guess_valid = 1'b0;
   logic       score_valid = 1'b0;
   logic [1:0] strike = 2'd0;
   logic       on_game;
   logic       cur_player;
   logic       score_req;
   logic       commit_p1;
   logic       commit_p2;
   logic       hist_clear;
   logic       reject;
   logic       timeout;
   logic [3:0] round;
   logic       game_over;
   logic [1:0] winner;

   int n_checks = 0;
   int n_errors = 0;
   int n_c1 = 0;
   int n_c2 = 0;
   int n_both = 0;

   turn_sequencer #(
      .MAX_ROUNDS    (4),
      .TIMEOUT_CYCLES(8),
      .TW            (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .enter      (enter),
      .guess_valid(guess_valid),
      .score_valid(score_valid),
      .strike     (strike),
      .on_game    (on_game),
      .cur_player (cur_player),
      .score_req  (score_req),
      .commit_p1  (commit_p1),
      .commit_p2  (commit_p2),
      .hist_clear (hist_clear),
      .reject     (reject),
      .timeout    (timeout),
      .round      (round),
      .game_over  (game_over),
      .winner     (winner)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (commit_p1) n_c1++;
      if (commit_p2) n_c2++;
      if (commit_p1 && commit_p2) n_both++;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_game();
      start = 1'b1;
      tick();
      start = 1'b0;
      check_eq("start_hist_clear", 32'(hist_clear), 1);
      check_eq("start_on_game", 32'(on_game), 1);
      check_eq("start_cur_player", 32'(cur_player), 0);
      check_eq("start_round", 32'(round), 0);
      check_eq("start_winner", 32'(winner), 0);
      check_eq("start_game_over", 32'(game_over), 0);
   endtask

   task automatic play_turn(input logic p, input logic [1:0] s);
      enter = 1'b1;
      guess_valid = 1'b1;
      tick();
      enter = 1'b0;
      guess_valid = 1'b0;
      check_eq("score_req_enter_p1", 32'(score_req), 1);
      tick();
      check_eq("score_req_one_cycle", 32'(score_req), 0);
      score_valid = 1'b1;
      strike = s;
      tick();
      score_valid = 1'b0;
      strike = 2'd0;
      check_eq("commit_not_early", 32'(commit_p1 | commit_p2), 0);
      tick();
      check_eq("commit_p1_val", 32'(commit_p1), 32'(!p));
      check_eq("commit_p2_val", 32'(commit_p2), 32'(p));
      check_eq("on_game_turn", 32'(on_game), 1);
   endtask

   task automatic play_round(input logic [1:0] s1, input logic [1:0] s2,
                             input int exp_round, input int exp_go, input int exp_win);
      play_turn(1'b0, s1);
      check_eq("cur_player_after_p1", 32'(cur_player), 1);
      play_turn(1'b1, s2);
      tick();
      check_eq("round_count", 32'(round), 32'(exp_round));
      check_eq("game_over_flag", 32'(game_over), 32'(exp_go));
      check_eq("winner_val", 32'(winner), 32'(exp_win));
      check_eq("on_game_round_end", 32'(on_game), 32'(exp_go == 0));
      if (exp_go == 0) check_eq("cur_player_new_round", 32'(cur_player), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c1_base;
      int c2_base;

      rst = 1'b0;
      tick();
      tick();
      check_eq("rst_on_game", 32'(on_game), 0);
      check_eq("rst_cur_player", 32'(cur_player), 0);
      check_eq("rst_round", 32'(round), 0);
      check_eq("rst_winner", 32'(winner), 0);
      check_eq("rst_game_over", 32'(game_over), 0);
      check_eq("rst_strobes", 32'({score_req, commit_p1, commit_p2, hist_clear, reject, timeout}), 0);
      rst = 1'b1;
      tick();

      // Four full rounds, no winner
      c1_base = n_c1;
      c2_base = n_c2;
      start_game();
      play_round(2'd1, 2'd2, 1, 0, 0);
      play_round(2'd0, 2'd1, 2, 0, 0);
      play_round(2'd2, 2'd2, 3, 0, 0);
      play_round(2'd1, 2'd0, 4, 1, 0);
      check_eq("count_commit_p1", 32'(n_c1 - c1_base), 4);
      check_eq("count_commit_p2", 32'(n_c2 - c2_base), 4);
      tick();
      check_eq("game_over_held", 32'(game_over), 1);

      // P1 wins in round 2; P2 still gets its turn
      start_game();
      play_round(2'd0, 2'd1, 1, 0, 0);
      play_round(2'd3, 2'd1, 2, 1, 1);

      // Both reach 3 strikes in round 2: draw
      start_game();
      play_round(2'd1, 2'd0, 1, 0, 0);
      play_round(2'd3, 2'd3, 2, 1, 3);

      // Reject, and start ignored mid-game
      start_game();
      tick();
      enter = 1'b1;
      guess_valid = 1'b0;
      tick();
      enter = 1'b0;
      check_eq("reject_pulse", 32'(reject), 1);
      check_eq("reject_no_req", 32'(score_req), 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      check_eq("reject_one_cycle", 32'(reject), 0);
      tick();
      check_eq("start_ignored_turn", 32'(hist_clear), 0);

      // Timeout: P1 idle for TIMEOUT_CYCLES
      rst = 1'b0;
      tick();
      rst = 1'b1;
      c1_base = n_c1;
      start_game();
      for (int i = 0; i < 7; i++) begin
         tick();
         check_eq("no_early_timeout", 32'(timeout), 0);
      end
      tick();
      check_eq("timeout_pulse", 32'(timeout), 1);
      check_eq("timeout_cur_player", 32'(cur_player), 1);
      check_eq("timeout_no_commit", 32'(n_c1 - c1_base), 0);

      // P2 enters on the expiry cycle: enter wins
      for (int i = 0; i < 7; i++) tick();
      check_eq("expiry_no_timeout_yet", 32'(timeout), 0);
      enter = 1'b1;
      guess_valid = 1'b1;
      tick();
      enter = 1'b0;
      guess_valid = 1'b0;
      check_eq("expiry_enter_req", 32'(score_req), 1);
      check_eq("expiry_enter_no_to", 32'(timeout), 0);

      // Reset in SCORE, then a late score_valid
      c2_base = n_c2;
      rst = 1'b0;
      tick();
      rst = 1'b1;
      score_valid = 1'b1;
      strike = 2'd3;
      tick();
      score_valid = 1'b0;
      strike = 2'd0;
      check_eq("rst_score_on_game", 32'(on_game), 0);
      check_eq("rst_score_outs", 32'({cur_player, score_req, commit_p1, commit_p2,
                                       hist_clear, reject, timeout, game_over}), 0);
      check_eq("rst_score_round_win", 32'({round, winner}), 0);
      tick();
      tick();
      check_eq("rst_score_no_commit", 32'(n_c2 - c2_base), 0);
      check_eq("rst_score_still_idle", 32'(on_game), 0);
      check_eq("never_both_commits", 32'(n_both), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
